// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: byte-fed sequencer around a programmable serial pattern
// detector. Bytes arrive over a valid/ready handshake and are shifted MSB-first
// into a history register, one bit per clock. Matches of the low cfg_len bits
// against the stored pattern are counted per run, and a level interrupt is
// raised once the count reaches the threshold.
//
// Optional build macro: SEQ_SCAN_NOOVL_EN
//   undefined (default): overlapping matches are all counted.
//   defined            : each match clears history and valid-bit count, so the
//                        next match needs cfg_len fresh bits.
//
// Handshake: a byte transfers on a rising edge where data_valid and data_ready
// are both 1. data_ready is high only in WAIT. The source may hold data_valid
// low for any number of cycles; it should keep data_in stable while data_valid
// is high and data_ready is low.
module seq_scan_ctrl #(
   parameter int PAT_W  = 8,
   parameter int CNT_W  = 8,
   parameter int WCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [PAT_W-1:0]  cfg_pat,
   input  logic [3:0]        cfg_len,
   input  logic [WCNT_W-1:0] cfg_words,
   input  logic [CNT_W-1:0]  cfg_thresh,
   input  logic              start,
   input  logic              data_valid,
   input  logic [7:0]        data_in,
   output logic              data_ready,
   output logic              busy,
   output logic              match,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              done,
   output logic              irq
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] VC_MAX = 4'(PAT_W);

   state_t              r_state;
   logic [PAT_W-1:0]    r_pat;
   logic [3:0]          r_len;
   logic [WCNT_W-1:0]   r_words;
   logic [CNT_W-1:0]    r_thresh;
   logic [WCNT_W-1:0]   r_wcnt;
   logic [7:0]          r_sreg;
   logic [2:0]          r_bidx;
   logic [PAT_W-1:0]    r_hist;
   logic [3:0]          r_vcnt;

   logic                w_bit;
   logic [PAT_W-1:0]    w_hist_nxt;
   logic [3:0]          w_vcnt_nxt;
   logic [PAT_W-1:0]    w_mask;
   logic                w_len_ok;
   logic                w_hit;

   // Match evaluation on the history as it will be after the current shift.
   // The mask wraps to all-ones when r_len equals PAT_W.
   always_comb begin
      w_bit      = r_sreg[7];
      w_hist_nxt = (r_hist << 1) | PAT_W'(w_bit);
      w_vcnt_nxt = (r_vcnt == VC_MAX) ? r_vcnt : r_vcnt + 4'd1;
      w_mask     = (PAT_W'(1) << r_len) - PAT_W'(1);
      w_len_ok   = (r_len != 4'd0) && (r_len <= VC_MAX);
      w_hit      = w_len_ok && (w_vcnt_nxt >= r_len) &&
                   ((w_hist_nxt & w_mask) == (r_pat & w_mask));
   end

   // Sequencer FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_pat      <= '0;
         r_len      <= '0;
         r_words    <= '0;
         r_thresh   <= '0;
         r_wcnt     <= '0;
         r_sreg     <= '0;
         r_bidx     <= '0;
         r_hist     <= '0;
         r_vcnt     <= '0;
         data_ready <= 1'b0;
         busy       <= 1'b0;
         match      <= 1'b0;
         match_cnt  <= '0;
         done       <= 1'b0;
         irq        <= 1'b0;
      end else begin
         match <= 1'b0;
         done  <= 1'b0;
         // irq tracks the registered count while a run is active and holds
         // its last value in IDLE until the next start.
         if (r_state != S_IDLE) begin
            irq <= (r_thresh != '0) && (match_cnt >= r_thresh);
         end
         case (r_state)
            S_IDLE: begin
               data_ready <= 1'b0;
               busy       <= 1'b0;
               if (cfg_we) begin
                  r_pat    <= cfg_pat;
                  r_len    <= cfg_len;
                  r_words  <= cfg_words;
                  r_thresh <= cfg_thresh;
               end
               if (start) begin
                  r_hist    <= '0;
                  r_vcnt    <= '0;
                  match_cnt <= '0;
                  irq       <= 1'b0;
                  busy      <= 1'b1;
                  if (r_words == '0) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                  end else begin
                     r_state    <= S_WAIT;
                     r_wcnt     <= r_words;
                     data_ready <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (data_valid && data_ready) begin
                  r_sreg     <= data_in;
                  r_bidx     <= 3'd7;
                  r_state    <= S_SHIFT;
                  data_ready <= 1'b0;
               end
            end
            S_SHIFT: begin
               r_sreg <= {r_sreg[6:0], 1'b0};
               r_bidx <= r_bidx - 3'd1;
               match  <= w_hit;
               if (w_hit && !(&match_cnt)) begin
                  match_cnt <= match_cnt + CNT_W'(1);
               end
`ifdef SEQ_SCAN_NOOVL_EN
               if (w_hit) begin
                  r_hist <= '0;
                  r_vcnt <= '0;
               end else begin
                  r_hist <= w_hist_nxt;
                  r_vcnt <= w_vcnt_nxt;
               end
`else
               r_hist <= w_hist_nxt;
               r_vcnt <= w_vcnt_nxt;
`endif
               if (r_bidx == 3'd0) begin
                  r_wcnt <= r_wcnt - WCNT_W'(1);
                  if (r_wcnt == WCNT_W'(1)) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                  end else begin
                     r_state    <= S_WAIT;
                     data_ready <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               r_state    <= S_IDLE;
               busy       <= 1'b0;
               data_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl. Two instances share all inputs: u_dut uses
// default widths, u_sat uses a 2-bit match counter to exercise saturation.
module tb_seq_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [7:0]  cfg_pat;
   logic [3:0]  cfg_len;
   logic [7:0]  cfg_words;
   logic [7:0]  cfg_thresh;
   logic        start;
   logic        data_valid;
   logic [7:0]  data_in;

   logic        m_ready, m_busy, m_match, m_done, m_irq;
   logic [7:0]  m_cnt;
   logic        s_ready, s_busy, s_match, s_done, s_irq;
   logic [1:0]  s_cnt;

   int checks = 0;
   int errors = 0;

`ifdef SEQ_SCAN_NOOVL_EN
   localparam logic [7:0] EXP_AA_M   = 8'h10;
   localparam int         EXP_AA_CNT = 1;
   localparam logic [7:0] EXP_FF_M   = 8'hAA;
   localparam logic [7:0] EXP_FF_I   = 8'hF0;
   localparam int         EXP_FF_CNT = 4;
`else
   localparam logic [7:0] EXP_AA_M   = 8'h50;
   localparam int         EXP_AA_CNT = 2;
   localparam logic [7:0] EXP_FF_M   = 8'hFE;
   localparam logic [7:0] EXP_FF_I   = 8'hF8;
   localparam int         EXP_FF_CNT = 7;
`endif

   seq_scan_ctrl u_dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
      .cfg_len(cfg_len), .cfg_words(cfg_words), .cfg_thresh(cfg_thresh),
      .start(start), .data_valid(data_valid), .data_in(data_in),
      .data_ready(m_ready), .busy(m_busy), .match(m_match),
      .match_cnt(m_cnt), .done(m_done), .irq(m_irq)
   );

   seq_scan_ctrl #(.PAT_W(8), .CNT_W(2), .WCNT_W(8)) u_sat (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
      .cfg_len(cfg_len), .cfg_words(cfg_words), .cfg_thresh(cfg_thresh[1:0]),
      .start(start), .data_valid(data_valid), .data_in(data_in),
      .data_ready(s_ready), .busy(s_busy), .match(s_match),
      .match_cnt(s_cnt), .done(s_done), .irq(s_irq)
   );

   // clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic config_regs(input logic [7:0] pat, input logic [3:0] len,
                              input logic [7:0] words, input logic [7:0] thr);
      cfg_we = 1'b1; cfg_pat = pat; cfg_len = len; cfg_words = words; cfg_thresh = thr;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Hand one byte over (DUT must be in WAIT) and record 8 shift cycles.
   task automatic run_byte(input logic [7:0] b, output logic [7:0] mv,
                           output logic [7:0] smv, output logic [7:0] siv,
                           output int nd);
      mv = '0; smv = '0; siv = '0; nd = 0;
      data_valid = 1'b1; data_in = b;
      tick();
      data_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         mv[k]  = m_match;
         smv[k] = s_match;
         siv[k] = s_irq;
         if (m_done) nd++;
      end
   endtask

   initial begin
      logic [7:0] mv, smv, siv;
      int nd;
      int busy_low;

      // Reset held with start and data_valid asserted
      rst = 1'b0; cfg_we = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_words = '0;
      cfg_thresh = '0; start = 1'b1; data_valid = 1'b1; data_in = 8'hAA;
      tick(); tick(); tick();
      rst = 1'b1; start = 1'b0; data_valid = 1'b0;
      tick();
      chk("rst_busy",  m_busy,  1'b0);
      chk("rst_ready", m_ready, 1'b0);
      chk("rst_cnt",   m_cnt,   8'd0);
      chk("rst_irq",   m_irq,   1'b0);
      chk("rst_done",  m_done,  1'b0);
      chk("rst_match", m_match, 1'b0);

      // Overlapping pattern 10101 in byte 0xAA
      config_regs(8'b0001_0101, 4'd5, 8'd1, 8'd0);
      do_start();
      chk("ovl_busy",  m_busy,  1'b1);
      chk("ovl_ready", m_ready, 1'b1);
      run_byte(8'hAA, mv, smv, siv, nd);
      chk("ovl_match_vec", mv, EXP_AA_M);
      chk("ovl_done_cnt",  nd, 1);
      chk("ovl_done_last", m_done, 1'b1);
      chk("ovl_cnt_in_done", m_cnt, EXP_AA_CNT);
      tick();
      chk("ovl_done_clear", m_done, 1'b0);
      chk("ovl_idle_busy",  m_busy, 1'b0);
      chk("ovl_cnt",        m_cnt,  EXP_AA_CNT);
      chk("ovl_irq",        m_irq,  1'b0);

      // Pattern 0110 spanning bytes 0x01, 0x80, with a stall in WAIT
      config_regs(8'b0000_0110, 4'd4, 8'd2, 8'd0);
      do_start();
      tick(); tick(); tick(); tick(); tick();
      chk("stall_busy",  m_busy,  1'b1);
      chk("stall_ready", m_ready, 1'b1);
      run_byte(8'h01, mv, smv, siv, nd);
      chk("xb_b1_match", mv, 8'h00);
      chk("xb_b1_done",  nd, 0);
      chk("xb_b1_ready", m_ready, 1'b1);
      run_byte(8'h80, mv, smv, siv, nd);
      chk("xb_b2_match", mv, 8'h02);
      chk("xb_b2_done",  nd, 1);
      tick();
      chk("xb_cnt", m_cnt, 8'd1);

      // Threshold and saturation: pattern 11 over byte 0xFF, threshold 2
      config_regs(8'b0000_0011, 4'd2, 8'd1, 8'd2);
      do_start();
      chk("sat_cnt_start", s_cnt, 2'd0);
      run_byte(8'hFF, mv, smv, siv, nd);
      chk("sat_match_vec", smv, EXP_FF_M);
      chk("sat_irq_vec",   siv, EXP_FF_I);
      chk("sat_cnt",       s_cnt, 2'd3);
      chk("main_ff_cnt",   m_cnt, EXP_FF_CNT);
      tick();
      tick(); tick();
      chk("sat_irq_held",  s_irq, 1'b1);
      chk("main_irq_held", m_irq, 1'b1);
      chk("sat_cnt_held",  s_cnt, 2'd3);

      // Zero-word run: straight to DONE, also clears irq and count
      config_regs(8'b0000_0011, 4'd2, 8'd0, 8'd2);
      chk("w0_irq_before", s_irq, 1'b1);
      do_start();
      chk("w0_done",  m_done,  1'b1);
      chk("w0_ready", m_ready, 1'b0);
      chk("w0_busy",  m_busy,  1'b1);
      chk("w0_cnt",   s_cnt,   2'd0);
      chk("w0_irq",   s_irq,   1'b0);
      tick();
      chk("w0_done_clear", m_done, 1'b0);
      chk("w0_idle",       m_busy, 1'b0);
      chk("w0_ready_idle", m_ready, 1'b0);

      // start and cfg_we during SHIFT must be ignored
      config_regs(8'b0001_0101, 4'd5, 8'd1, 8'd0);
      do_start();
      data_valid = 1'b1; data_in = 8'hAA;
      tick();
      data_valid = 1'b0;
      mv = '0; nd = 0; busy_low = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 1) begin
            start = 1'b1; cfg_we = 1'b1;
            cfg_pat = 8'h03; cfg_len = 4'd2; cfg_words = 8'd3; cfg_thresh = 8'd1;
         end else begin
            start = 1'b0; cfg_we = 1'b0;
         end
         tick();
         mv[k] = m_match;
         if (m_done) nd++;
         if (!m_busy) busy_low++;
      end
      chk("ign_match_vec", mv, EXP_AA_M);
      chk("ign_done",      nd, 1);
      chk("ign_busy",      busy_low, 0);
      tick();
      // Rerun with no config write: stored values must be the earlier ones
      do_start();
      run_byte(8'hAA, mv, smv, siv, nd);
      chk("ign_rerun_match", mv, EXP_AA_M);
      chk("ign_rerun_done",  nd, 1);
      tick();

      // Reset mid-SHIFT aborts without done and clears config
      do_start();
      data_valid = 1'b1; data_in = 8'hAA;
      tick();
      data_valid = 1'b0;
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mrst_busy",  m_busy,  1'b0);
      chk("mrst_ready", m_ready, 1'b0);
      chk("mrst_done",  m_done,  1'b0);
      chk("mrst_cnt",   m_cnt,   8'd0);
      nd = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (m_done) nd++;
      end
      chk("mrst_no_done", nd, 0);
      do_start();
      chk("mrst_words0_done", m_done, 1'b1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Sequencer around a programmable serial pattern detector.
- Accepts parallel bytes over a valid/ready handshake and shifts each byte into the detector MSB-first, one bit per clock.
- Counts pattern matches over a run of a configured number of bytes and raises a threshold interrupt.
- Sits between a byte source (UART/FIFO) and the control/status logic that previously drove fixed-pattern detectors directly.

Parameters:
- PAT_W, 8, maximum pattern length in bits (2..15).
- CNT_W, 8, width of the match counter and threshold.
- WCNT_W, 8, width of the word-count configuration.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- cfg_we  in  1  config write strobe; ignored while busy=1.
- cfg_pat  in  PAT_W  pattern; the bit at index cfg_len-1 is the first bit seen.
- cfg_len  in  4  pattern length; legal 1..PAT_W; other values stored but disable matching.
- cfg_words  in  WCNT_W  number of bytes per run.
- cfg_thresh  in  CNT_W  irq threshold; 0 disables irq.
- start  in  1  begin run; ignored while busy=1.
- data_valid  in  1  byte available.
- data_in  in  8  byte.
- data_ready  out  1  byte accepted when data_valid and data_ready are both 1.
- busy  out  1  run in progress.
- match  out  1  one-cycle pulse per detected match.
- match_cnt  out  CNT_W  matches this run, saturating.
- done  out  1  one-cycle pulse at end of run.
- irq  out  1  level; match_cnt >= cfg_thresh (registered value) and threshold != 0.

Behaviour:
- Reset (rst=0 at rising edge) forces:
  - state IDLE;
  - all outputs 0;
  - stored pattern, length, words and threshold all 0;
  - history and bit counters cleared.
- Reset mid-run aborts immediately; no done pulse.
- Config registers load on cfg_we in IDLE only.
- States:
  - IDLE: busy=0, data_ready=0. On start: clear history, valid-bit count, match_cnt and irq. If words=0, go to DONE; else go to WAIT with word counter = words.
  - WAIT: busy=1, data_ready=1. On handshake: latch data_in into the shift register, go to SHIFT, bit index = 7.
  - SHIFT: busy=1, data_ready=0, exactly 8 cycles.
    - Each cycle shifts the current bit (MSB first) into the PAT_W-bit history; valid-bit count saturates at PAT_W.
    - After the 8th bit, decrement the word counter: non-zero goes to WAIT, zero goes to DONE.
  - DONE: busy=1, done=1 for one cycle, then IDLE.
- Match rule:
  - Evaluated on the updated history; match is registered.
  - match is high in the cycle after the edge that shifts in the completing bit.
  - Condition: valid-bit count >= len, len legal, and the low len bits of the history equal the low len bits of the pattern.
  - Overlapping matches count.
  - History and valid-bit count persist across bytes within a run.
- Back-to-back bytes: minimum 9 cycles per byte (1 WAIT + 8 SHIFT). WAIT may stall indefinitely; busy stays high.
- match_cnt increments with each match pulse and saturates at all-ones; match still pulses after saturation.
- irq:
  - Registered; updates the cycle after match_cnt reaches threshold.
  - Held through IDLE until the next start or reset.
- match_cnt holds its final value in IDLE.
- cfg_we and start while busy are ignored, with no side effects.

Optional Feature:
- Macro: SEQ_SCAN_NOOVL_EN.
- Defined: non-overlapping detection. On a match, the history and valid-bit count are cleared, so the next match needs len fresh bits.
- Undefined: overlapping detection as above.

Test Plan:
- Reset held with start=1, data_valid=1 -> after release: busy=0, data_ready=0, match_cnt=0, irq=0, done=0.
- Overlap: pat=5'b10101, len=5, words=1, thresh=0; byte 0xAA accepted at edge E -> match high after edges E+5 and E+7; match_cnt=2; done pulses once; irq stays 0.
- With SEQ_SCAN_NOOVL_EN: same stimulus -> single match after edge E+5; match_cnt=1.
- Cross-byte: pat=4'b0110, len=4, words=2, bytes 0x01 then 0x80 -> exactly one match, on the 2nd bit of byte 2; match_cnt=1.
- Threshold and saturation: CNT_W=2, thresh=2, pat=2'b11, len=2, byte 0xFF -> 7 match pulses; match_cnt saturates at 3; irq rises the cycle after the 2nd match; a new start clears irq and match_cnt.
- Corner cases:
  - words=0 start -> done the cycle after IDLE exit, data_ready never asserts.
  - start/cfg_we during SHIFT -> ignored.
  - rst=0 mid-SHIFT -> IDLE next cycle, no done pulse.
